cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates line-refill and line-writeback requests from the ICache and DCache onto the single shared 8-beat burst engine, which has one read channel and one write channel. It sits between the caches and the burst engine. It owns three jobs:
- ordering: reads to a line with a writeback in flight wait for that writeback;
- fairness: DCache-priority reads with an ICache starvation guard;
- completion routing: the burst engine's done pulses go back to the owning requester.

## Interface
Parameters
- ADDR_W, 32, address width.
- LINE_OFF, 5, line-offset bits (32-byte line); zeroed in all forwarded addresses.
- STARVE_MAX, 4, consecutive DCache read grants allowed while ICache is waiting.

Ports
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ic_req_i  in  1  ICache refill request; held high until ic_done_o.
- ic_addr_i  in  ADDR_W  ICache refill address; stable while ic_req_i is high.
- ic_gnt_o  out  1  one-cycle pulse: ICache request accepted.
- ic_done_o  out  1  one-cycle pulse: ICache refill complete.
- dc_rreq_i, dc_raddr_i, dc_rgnt_o, dc_rdone_o: DCache refill; same rules and widths as the ic_* ports.
- dc_wreq_i, dc_waddr_i, dc_wgnt_o, dc_wdone_o: DCache writeback; same rules and widths as the ic_* ports.
- mem_rreq_o  out  1  read burst active; held high until mem_rdone_i.
- mem_raddr_o  out  ADDR_W  line-aligned read address.
- mem_rid_o  out  1  read owner: 0 = ICache, 1 = DCache.
- mem_rdone_i  in  1  one-cycle pulse: last read beat received.
- mem_wreq_o  out  1  write burst active; held high until mem_wdone_i.
- mem_waddr_o  out  ADDR_W  line-aligned write address.
- mem_wdone_i  in  1  one-cycle pulse: last write response received.

## Operation
- Read FSM states: R_IDLE, R_IC, R_DC.
  - R_IDLE to R_IC or R_DC on a grant.
  - R_IC or R_DC to R_IDLE on mem_rdone_i.
- Write FSM states: W_IDLE, W_BUSY.
  - W_IDLE to W_BUSY when dc_wreq_i is high (eligible only in W_IDLE).
  - W_BUSY to W_IDLE on mem_wdone_i.
- Line addresses:
  - On grant, {addr[ADDR_W-1:LINE_OFF], LINE_OFF'b0} is latched into mem_raddr_o / mem_waddr_o.
  - The latched value stays stable through the burst and holds after it ends.
- Hazard: a read is eligible only if its line differs from the active write line.
  - The active write line is mem_waddr_o while in W_BUSY.
  - In the cycle a write is being granted, it is dc_waddr_i.
  - Write wins: a read of the same line granted in the same cycle is blocked.
- Read priority:
  - Default: DCache before ICache.
  - Override: if starve_cnt == STARVE_MAX and ICache is eligible, ICache wins.
- Starvation counter starve_cnt, 0..STARVE_MAX, saturating:
  - Increments on each DCache read grant while ic_req_i is high.
  - Clears on an ICache grant, or in any cycle ic_req_i is low.
- Done masking: a requester's req is ignored in the cycle its own done_o is high. This prevents a regrant before the requester deasserts.
- Read and write channels run concurrently and independently, apart from the hazard check.

## Timing
- Reset value: every output is 0, both FSMs are idle, starve_cnt = 0.
- Reset mid-burst: state is abandoned immediately. No done pulse is issued; mem_rreq_o and mem_wreq_o drop the next cycle.
- Grant: req sampled in cycle t.
  - gnt_o pulses in t+1.
  - mem_*req_o is high from t+1.
  - The FSM is in its busy state from t+1.
- Completion: mem_*done_i in cycle t.
  - done_o pulses in t+1.
  - mem_*req_o is low in t+1.
  - The FSM is idle in t+1; a new grant can issue in t+2 at the earliest.
- Fixed arbitration latency: 1 cycle. Back-to-back bursts on one channel have 1 idle cycle between them.
- mem_rdone_i outside R_IC/R_DC and mem_wdone_i outside W_BUSY are ignored.

## Test plan
- Single ICache refill:
  - Stimulus: ic_addr_i = 0x1FC0_0014.
  - Required: ic_gnt_o at t+1, mem_raddr_o = 0x1FC0_0000, mem_rid_o = 0.
  - Then mem_rdone_i at t+9 gives ic_done_o at t+10, and no regrant while ic_req_i is still high that cycle.
- Simultaneous ICache and DCache read requests:
  - Stimulus: both requests high in the same cycle.
  - Required: DCache granted first; ICache granted 2 cycles after the DCache mem_rdone_i.
- Starvation guard:
  - Stimulus: ic_req_i held high; DCache issues 5 back-to-back refills.
  - Required: grants in order D, D, D, D, I, D; starve_cnt returns to 0 after the I grant.
- Hazard, same cycle:
  - Stimulus: dc_wreq_i with dc_waddr_i = 0x8000_0040 and dc_rreq_i with dc_raddr_i = 0x8000_005C, both in the same cycle.
  - Required: write granted; read held until 1 cycle after dc_wdone_o.
  - Control case: a read to 0x8000_0060 is granted concurrently with the write.
- Reset mid-burst:
  - Stimulus: rst asserted during R_DC and W_BUSY.
  - Required: all outputs 0 the next cycle; no done pulses; a later mem_rdone_i is ignored.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Request/grant/done bundle between the two caches, the shared burst engine
// and cache_mem_arbiter. The arbiter takes the slave view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_gnt_o;
  logic              ic_done_o;

  logic              dc_rreq_i;
  logic [ADDR_W-1:0] dc_raddr_i;
  logic              dc_rgnt_o;
  logic              dc_rdone_o;

  logic              dc_wreq_i;
  logic [ADDR_W-1:0] dc_waddr_i;
  logic              dc_wgnt_o;
  logic              dc_wdone_o;

  logic              mem_rreq_o;
  logic [ADDR_W-1:0] mem_raddr_o;
  logic              mem_rid_o;
  logic              mem_rdone_i;

  logic              mem_wreq_o;
  logic [ADDR_W-1:0] mem_waddr_o;
  logic              mem_wdone_i;

  modport slave (
    input  ic_req_i, ic_addr_i, dc_rreq_i, dc_raddr_i, dc_wreq_i, dc_waddr_i,
           mem_rdone_i, mem_wdone_i,
    output ic_gnt_o, ic_done_o, dc_rgnt_o, dc_rdone_o, dc_wgnt_o, dc_wdone_o,
           mem_rreq_o, mem_raddr_o, mem_rid_o, mem_wreq_o, mem_waddr_o
  );

  modport master (
    output ic_req_i, ic_addr_i, dc_rreq_i, dc_raddr_i, dc_wreq_i, dc_waddr_i,
           mem_rdone_i, mem_wdone_i,
    input  ic_gnt_o, ic_done_o, dc_rgnt_o, dc_rdone_o, dc_wgnt_o, dc_wdone_o,
           mem_rreq_o, mem_raddr_o, mem_rid_o, mem_wreq_o, mem_waddr_o
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one 8-beat burst engine (one read, one write channel) between ICache
// refills, DCache refills and DCache writebacks.
//   state  | meaning
//   R_IDLE | read channel free, arbitrating
//   R_IC   | ICache refill burst in flight
//   R_DC   | DCache refill burst in flight
//   W_IDLE | write channel free
//   W_BUSY | DCache writeback burst in flight
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_OFF   = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.slave  bus
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {R_IDLE, R_IC, R_DC} r_state_t;
  typedef enum logic       {W_IDLE, W_BUSY}     w_state_t;

  r_state_t          r_state, r_next;
  w_state_t          w_state, w_next;
  logic [SC_W-1:0]   starve_cnt;

  logic              ic_live, dc_live, w_grant, wl_valid;
  logic              ic_ok, dc_ok, starve_hit;
  logic              ic_grant, dc_grant;
  logic [ADDR_W-1:0] wl;

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
  endfunction

  // A requester is deaf in its own done cycle so a still-high req is not regranted.
  always_comb begin
    ic_live    = bus.ic_req_i  & ~bus.ic_done_o;
    dc_live    = bus.dc_rreq_i & ~bus.dc_rdone_o;
    w_grant    = (w_state == W_IDLE) & bus.dc_wreq_i & ~bus.dc_wdone_o;
    wl_valid   = (w_state == W_BUSY) | w_grant;
    wl         = (w_state == W_BUSY) ? bus.mem_waddr_o : line_of(bus.dc_waddr_i);
    ic_ok      = ic_live & ~(wl_valid & (line_of(bus.ic_addr_i)  == wl));
    dc_ok      = dc_live & ~(wl_valid & (line_of(bus.dc_raddr_i) == wl));
    starve_hit = (starve_cnt == SC_W'(STARVE_MAX));
  end

  always_comb begin
    r_next   = r_state;
    ic_grant = 1'b0;
    dc_grant = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (dc_ok && !(starve_hit && ic_ok)) begin
          dc_grant = 1'b1;
          r_next   = R_DC;
        end else if (ic_ok) begin
          ic_grant = 1'b1;
          r_next   = R_IC;
        end
      end
      R_IC, R_DC: begin
        if (bus.mem_rdone_i) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (w_grant) w_next = W_BUSY;
      W_BUSY: if (bus.mem_wdone_i) w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= R_IDLE;
      w_state         <= W_IDLE;
      starve_cnt      <= '0;
      bus.ic_gnt_o    <= 1'b0;
      bus.ic_done_o   <= 1'b0;
      bus.dc_rgnt_o   <= 1'b0;
      bus.dc_rdone_o  <= 1'b0;
      bus.dc_wgnt_o   <= 1'b0;
      bus.dc_wdone_o  <= 1'b0;
      bus.mem_raddr_o <= '0;
      bus.mem_rid_o   <= 1'b0;
      bus.mem_waddr_o <= '0;
    end else begin
      r_state        <= r_next;
      w_state        <= w_next;
      bus.ic_gnt_o   <= ic_grant;
      bus.dc_rgnt_o  <= dc_grant;
      bus.dc_wgnt_o  <= w_grant;
      bus.ic_done_o  <= (r_state == R_IC) & bus.mem_rdone_i;
      bus.dc_rdone_o <= (r_state == R_DC) & bus.mem_rdone_i;
      bus.dc_wdone_o <= (w_state == W_BUSY) & bus.mem_wdone_i;

      if (ic_grant) begin
        bus.mem_raddr_o <= line_of(bus.ic_addr_i);
        bus.mem_rid_o   <= 1'b0;
      end else if (dc_grant) begin
        bus.mem_raddr_o <= line_of(bus.dc_raddr_i);
        bus.mem_rid_o   <= 1'b1;
      end

      if (w_grant) bus.mem_waddr_o <= line_of(bus.dc_waddr_i);

      if (!bus.ic_req_i || ic_grant)    starve_cnt <= '0;
      else if (dc_grant && !starve_hit) starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  assign bus.mem_rreq_o = (r_state != R_IDLE);
  assign bus.mem_wreq_o = (w_state == W_BUSY);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a line-number based reference model is
// compared against the DUT every cycle, plus hand-computed checks per scenario.
module tb_cache_mem_arbiter;
  localparam int AW   = 32;
  localparam int LO   = 5;
  localparam int SMAX = 4;

  logic clk, rst;
  cache_mem_arbiter_if #(.ADDR_W(AW)) bus ();

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_OFF(LO), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Reference model: read owner (-1 none, 0 ICache, 1 DCache), line numbers.
  int          m_rown, m_starve;
  logic        m_wbusy, m_rid;
  logic        m_ic_gnt, m_ic_done, m_dc_rgnt, m_dc_rdone, m_dc_wgnt, m_dc_wdone;
  logic [31:0] m_rline, m_wline;

  logic        m_ic_live, m_dc_live, m_wstart, m_wl_valid, m_ic_ok, m_dc_ok;
  logic        m_take_i, m_take_d;
  logic [31:0] m_wl;

  always_comb begin
    m_ic_live  = bus.ic_req_i  && !m_ic_done;
    m_dc_live  = bus.dc_rreq_i && !m_dc_rdone;
    m_wstart   = !m_wbusy && bus.dc_wreq_i && !m_dc_wdone;
    m_wl_valid = m_wbusy || m_wstart;
    m_wl       = m_wbusy ? m_wline : (bus.dc_waddr_i >> LO);
    m_ic_ok    = m_ic_live && !(m_wl_valid && ((bus.ic_addr_i  >> LO) == m_wl));
    m_dc_ok    = m_dc_live && !(m_wl_valid && ((bus.dc_raddr_i >> LO) == m_wl));
    m_take_i   = (m_rown < 0) && m_ic_ok && ((m_starve == SMAX) || !m_dc_ok);
    m_take_d   = (m_rown < 0) && m_dc_ok && !m_take_i;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_rown <= -1; m_wbusy <= 1'b0; m_rid <= 1'b0; m_starve <= 0;
      m_rline <= '0; m_wline <= '0;
      m_ic_gnt <= 1'b0; m_ic_done <= 1'b0; m_dc_rgnt <= 1'b0;
      m_dc_rdone <= 1'b0; m_dc_wgnt <= 1'b0; m_dc_wdone <= 1'b0;
    end else begin
      m_ic_gnt   <= m_take_i;
      m_dc_rgnt  <= m_take_d;
      m_dc_wgnt  <= m_wstart;
      m_ic_done  <= (m_rown == 0) && bus.mem_rdone_i;
      m_dc_rdone <= (m_rown == 1) && bus.mem_rdone_i;
      m_dc_wdone <= m_wbusy && bus.mem_wdone_i;
      if (m_take_i) begin
        m_rown <= 0; m_rline <= bus.ic_addr_i >> LO; m_rid <= 1'b0;
      end else if (m_take_d) begin
        m_rown <= 1; m_rline <= bus.dc_raddr_i >> LO; m_rid <= 1'b1;
      end else if (m_rown >= 0 && bus.mem_rdone_i) begin
        m_rown <= -1;
      end
      if (m_wstart) begin
        m_wbusy <= 1'b1; m_wline <= bus.dc_waddr_i >> LO;
      end else if (m_wbusy && bus.mem_wdone_i) begin
        m_wbusy <= 1'b0;
      end
      if (!bus.ic_req_i || m_take_i) m_starve <= 0;
      else if (m_take_d)             m_starve <= (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ic_gnt",    32'(bus.ic_gnt_o),   32'(m_ic_gnt));
      chk("ic_done",   32'(bus.ic_done_o),  32'(m_ic_done));
      chk("dc_rgnt",   32'(bus.dc_rgnt_o),  32'(m_dc_rgnt));
      chk("dc_rdone",  32'(bus.dc_rdone_o), 32'(m_dc_rdone));
      chk("dc_wgnt",   32'(bus.dc_wgnt_o),  32'(m_dc_wgnt));
      chk("dc_wdone",  32'(bus.dc_wdone_o), 32'(m_dc_wdone));
      chk("mem_rreq",  32'(bus.mem_rreq_o), 32'(m_rown >= 0));
      chk("mem_raddr", bus.mem_raddr_o,     m_rline << LO);
      chk("mem_rid",   32'(bus.mem_rid_o),  32'(m_rid));
      chk("mem_wreq",  32'(bus.mem_wreq_o), 32'(m_wbusy));
      chk("mem_waddr", bus.mem_waddr_o,     m_wline << LO);
      chk("starve",    32'(dut.starve_cnt), 32'(m_starve));
    end
  end

  bit  rec_on = 1'b0;
  byte order[$];
  always @(negedge clk) begin
    if (rec_on) begin
      if (bus.dc_rgnt_o) order.push_back("D");
      if (bus.ic_gnt_o)  order.push_back("I");
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rreq"},  32'(bus.mem_rreq_o), 0);
    chk({nm, "_wreq"},  32'(bus.mem_wreq_o), 0);
    chk({nm, "_raddr"}, bus.mem_raddr_o, 0);
    chk({nm, "_waddr"}, bus.mem_waddr_o, 0);
    chk({nm, "_rid"},   32'(bus.mem_rid_o), 0);
    chk({nm, "_pulses"}, 32'({bus.ic_gnt_o, bus.ic_done_o, bus.dc_rgnt_o,
                              bus.dc_rdone_o, bus.dc_wgnt_o, bus.dc_wdone_o}), 0);
    chk({nm, "_starve"}, 32'(dut.starve_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string want;
    rst = 1'b1;
    bus.ic_req_i = 1'b0;  bus.ic_addr_i  = '0;
    bus.dc_rreq_i = 1'b0; bus.dc_raddr_i = '0;
    bus.dc_wreq_i = 1'b0; bus.dc_waddr_i = '0;
    bus.mem_rdone_i = 1'b0; bus.mem_wdone_i = 1'b0;
    tick(3);
    cmp_on = 1'b1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // Single ICache refill
    bus.ic_addr_i = 32'h1FC0_0014; bus.ic_req_i = 1'b1;
    tick;
    chk("t1_gnt",   32'(bus.ic_gnt_o), 1);
    chk("t1_rreq",  32'(bus.mem_rreq_o), 1);
    chk("t1_raddr", bus.mem_raddr_o, 32'h1FC0_0000);
    chk("t1_rid",   32'(bus.mem_rid_o), 0);
    tick(8);
    bus.mem_rdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0;
    chk("t1_done",     32'(bus.ic_done_o), 1);
    chk("t1_rreq_low", 32'(bus.mem_rreq_o), 0);
    tick;
    chk("t1_no_regrant", 32'(bus.ic_gnt_o), 0);
    chk("t1_addr_hold",  bus.mem_raddr_o, 32'h1FC0_0000);
    bus.ic_req_i = 1'b0;
    tick(2);

    // Simultaneous ICache and DCache reads
    bus.ic_addr_i = 32'h0000_1000;  bus.ic_req_i = 1'b1;
    bus.dc_raddr_i = 32'h0000_2024; bus.dc_rreq_i = 1'b1;
    tick;
    chk("t2_dc_first", 32'(bus.dc_rgnt_o), 1);
    chk("t2_ic_wait",  32'(bus.ic_gnt_o), 0);
    chk("t2_raddr",    bus.mem_raddr_o, 32'h0000_2020);
    chk("t2_rid",      32'(bus.mem_rid_o), 1);
    tick(3);
    bus.mem_rdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0;
    chk("t2_dc_done", 32'(bus.dc_rdone_o), 1);
    chk("t2_ic_not_yet", 32'(bus.ic_gnt_o), 0);
    bus.dc_rreq_i = 1'b0;
    tick;
    chk("t2_ic_gnt", 32'(bus.ic_gnt_o), 1);
    chk("t2_raddr2", bus.mem_raddr_o, 32'h0000_1000);
    tick(2);
    bus.mem_rdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0;
    chk("t2_ic_done", 32'(bus.ic_done_o), 1);
    bus.ic_req_i = 1'b0;
    tick(2);

    // Starvation guard: a writeback to the ICache line blocks ICache while DCache refills
    order.delete();
    rec_on = 1'b1;
    bus.dc_waddr_i = 32'h4000_0000; bus.dc_wreq_i = 1'b1;
    bus.ic_addr_i  = 32'h4000_0008; bus.ic_req_i  = 1'b1;
    tick;
    chk("t3_wgnt",     32'(bus.dc_wgnt_o), 1);
    chk("t3_ic_block", 32'(bus.ic_gnt_o), 0);
    chk("t3_waddr",    bus.mem_waddr_o, 32'h4000_0000);
    for (int k = 0; k < 4; k++) begin
      bus.dc_raddr_i = 32'h5000_0000 + 32'(k) * 32'h20; bus.dc_rreq_i = 1'b1;
      tick;
      chk("t3_dgnt", 32'(bus.dc_rgnt_o), 1);
      tick(2);
      bus.mem_rdone_i = 1'b1;
      tick;
      bus.mem_rdone_i = 1'b0;
      chk("t3_ddone", 32'(bus.dc_rdone_o), 1);
      bus.dc_rreq_i = 1'b0;
      tick;
    end
    chk("t3_starve_full", 32'(dut.starve_cnt), 4);
    bus.mem_wdone_i = 1'b1;
    tick;
    bus.mem_wdone_i = 1'b0;
    chk("t3_wdone", 32'(bus.dc_wdone_o), 1);
    bus.dc_wreq_i = 1'b0;
    bus.dc_raddr_i = 32'h5000_0080; bus.dc_rreq_i = 1'b1;
    tick;
    chk("t3_ic_wins",    32'(bus.ic_gnt_o), 1);
    chk("t3_dc_loses",   32'(bus.dc_rgnt_o), 0);
    chk("t3_starve_clr", 32'(dut.starve_cnt), 0);
    tick(2);
    bus.mem_rdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0;
    chk("t3_ic_done", 32'(bus.ic_done_o), 1);
    bus.ic_req_i = 1'b0;
    tick;
    chk("t3_d_after", 32'(bus.dc_rgnt_o), 1);
    tick(2);
    bus.mem_rdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0;
    bus.dc_rreq_i = 1'b0;
    tick;
    rec_on = 1'b0;
    want = "DDDDID";
    chk("t3_count", 32'(order.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) chk("t3_order", 32'(order[i]), 32'(want[i]));
    tick;

    // Same-cycle hazard with an unrelated-line ICache read as control
    bus.dc_waddr_i = 32'h8000_0040; bus.dc_wreq_i = 1'b1;
    bus.dc_raddr_i = 32'h8000_005C; bus.dc_rreq_i = 1'b1;
    bus.ic_addr_i  = 32'h8000_0060; bus.ic_req_i  = 1'b1;
    tick;
    chk("t4_wgnt",     32'(bus.dc_wgnt_o), 1);
    chk("t4_ctrl_gnt", 32'(bus.ic_gnt_o), 1);
    chk("t4_rd_block", 32'(bus.dc_rgnt_o), 0);
    chk("t4_waddr",    bus.mem_waddr_o, 32'h8000_0040);
    chk("t4_raddr",    bus.mem_raddr_o, 32'h8000_0060);
    tick(2);
    bus.mem_rdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0;
    bus.ic_req_i = 1'b0;
    tick(2);
    chk("t4_still_held", 32'(bus.dc_rgnt_o), 0);
    bus.mem_wdone_i = 1'b1;
    tick;
    bus.mem_wdone_i = 1'b0;
    chk("t4_wdone",     32'(bus.dc_wdone_o), 1);
    chk("t4_held_wdone", 32'(bus.dc_rgnt_o), 0);
    bus.dc_wreq_i = 1'b0;
    tick;
    chk("t4_rd_gnt",   32'(bus.dc_rgnt_o), 1);
    chk("t4_rd_raddr", bus.mem_raddr_o, 32'h8000_0040);
    tick(2);
    bus.mem_rdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0;
    bus.dc_rreq_i = 1'b0;
    tick(2);

    // Reset in the middle of a read and a write burst
    bus.dc_raddr_i = 32'h0000_3000; bus.dc_rreq_i = 1'b1;
    bus.dc_waddr_i = 32'h0000_4000; bus.dc_wreq_i = 1'b1;
    tick;
    chk("t5_rgnt", 32'(bus.dc_rgnt_o), 1);
    chk("t5_wgnt", 32'(bus.dc_wgnt_o), 1);
    tick(2);
    rst = 1'b1;
    bus.dc_rreq_i = 1'b0; bus.dc_wreq_i = 1'b0;
    tick;
    chk_all_zero("t5_rst");
    rst = 1'b0;
    bus.mem_rdone_i = 1'b1; bus.mem_wdone_i = 1'b1;
    tick;
    bus.mem_rdone_i = 1'b0; bus.mem_wdone_i = 1'b0;
    tick;
    chk_all_zero("t5_after");
    tick(2);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
